// File: rtl/rr_sched.sv
// Round-robin scheduler: rotating find-first-set selection over W requesters,
// registered one-hot grant, offer/ack handshake, and ownership until release.
module rr_sched #(
    parameter  int W     = 8,
    localparam int ENC_W = $clog2(W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     req,
    input  logic             gnt_ack,
    input  logic             rel,
    output logic             gnt_v,
    output logic [W-1:0]     gnt,
    output logic [ENC_W-1:0] gnt_enc,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, OFFER, OWNED} state_t;

    state_t             state, state_n;
    logic [ENC_W-1:0]   ptr, ptr_n;
    logic               gnt_v_n, busy_n;
    logic [W-1:0]       gnt_n;
    logic [ENC_W-1:0]   gnt_enc_n;

    logic [ENC_W-1:0]   sel_hi, sel_lo, sel_k;
    logic               hit_hi, hit_lo;

    // Two-pass search: first set bit at or above ptr, else first set bit overall.
    always_comb begin
        sel_hi = '0;
        sel_lo = '0;
        hit_hi = 1'b0;
        hit_lo = 1'b0;
        for (int unsigned i = 0; i < W; i++) begin
            if (req[i] && !hit_lo) begin
                sel_lo = ENC_W'(i);
                hit_lo = 1'b1;
            end
            if (req[i] && !hit_hi && (ENC_W'(i) >= ptr)) begin
                sel_hi = ENC_W'(i);
                hit_hi = 1'b1;
            end
        end
        sel_k = hit_hi ? sel_hi : sel_lo;
    end

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        gnt_v_n   = gnt_v;
        gnt_n     = gnt;
        gnt_enc_n = gnt_enc;
        busy_n    = busy;
        unique case (state)
            IDLE: begin
                gnt_n = '0;
                if (|req) begin
                    state_n   = OFFER;
                    gnt_v_n   = 1'b1;
                    gnt_n     = W'(1) << sel_k;
                    gnt_enc_n = sel_k;
                end
            end
            OFFER: begin
                if (gnt_ack) begin
                    state_n = OWNED;
                    gnt_v_n = 1'b0;
                    busy_n  = 1'b1;
                    ptr_n   = (gnt_enc == ENC_W'(W - 1)) ? '0 : gnt_enc + 1'b1;
                end else if (!req[gnt_enc]) begin
                    state_n = IDLE;
                    gnt_v_n = 1'b0;
                    gnt_n   = '0;
                end
            end
            OWNED: begin
                if (rel) begin
                    busy_n = 1'b0;
                    if (|req) begin
                        state_n   = OFFER;
                        gnt_v_n   = 1'b1;
                        gnt_n     = W'(1) << sel_k;
                        gnt_enc_n = sel_k;
                    end else begin
                        state_n = IDLE;
                        gnt_n   = '0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            gnt_v   <= 1'b0;
            gnt     <= '0;
            gnt_enc <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            gnt_v   <= gnt_v_n;
            gnt     <= gnt_n;
            gnt_enc <= gnt_enc_n;
            busy    <= busy_n;
        end
    end

endmodule

// File: tb/tb_rr_sched.sv
// Bench for rr_sched: W=4 and W=5 instances checked each cycle against a
// queue-free behavioural model, plus directed literal expectations.
module tb_rr_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [3:0] r4 = '0;
    logic       a4 = 1'b0, l4 = 1'b0;
    logic       gv4, bz4;
    logic [3:0] g4;
    logic [1:0] e4;

    logic [4:0] r5 = '0;
    logic       a5 = 1'b0, l5 = 1'b0;
    logic       gv5, bz5;
    logic [4:0] g5;
    logic [2:0] e5;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    rr_sched #(.W(4)) u4 (
        .clk(clk), .rst(rst), .req(r4), .gnt_ack(a4), .rel(l4),
        .gnt_v(gv4), .gnt(g4), .gnt_enc(e4), .busy(bz4)
    );

    rr_sched #(.W(5)) u5 (
        .clk(clk), .rst(rst), .req(r5), .gnt_ack(a5), .rel(l5),
        .gnt_v(gv5), .gnt(g5), .gnt_enc(e5), .busy(bz5)
    );

    typedef struct {
        bit offer;
        bit own;
        int k;
        int ptr;
    } mdl_t;

    mdl_t m4 = '{0, 0, 0, 0};
    mdl_t m5 = '{0, 0, 0, 0};

    // Walk indices p, p+1, ... modulo w; first requester hit wins.
    function automatic int first_req(logic [63:0] r, int p, int w);
        for (int j = 0; j < w; j++) begin
            if (r[(p + j) % w]) return (p + j) % w;
        end
        return -1;
    endfunction

    function automatic mdl_t step(mdl_t m, int w, logic [63:0] r, bit ack, bit rl, bit rs);
        mdl_t n = m;
        int   f;
        if (rs) begin
            n.offer = 0; n.own = 0; n.k = 0; n.ptr = 0;
            return n;
        end
        if (m.offer) begin
            if (ack) begin
                n.offer = 0; n.own = 1; n.ptr = (m.k + 1) % w;
            end else if (!r[m.k]) begin
                n.offer = 0;
            end
        end else if (m.own) begin
            if (rl) begin
                n.own = 0;
                f = first_req(r, m.ptr, w);
                if (f >= 0) begin n.offer = 1; n.k = f; end
            end
        end else begin
            f = first_req(r, m.ptr, w);
            if (f >= 0) begin n.offer = 1; n.k = f; end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m4 <= step(m4, 4, {60'b0, r4}, a4, l4, rst);
        m5 <= step(m5, 5, {59'b0, r5}, a5, l5, rst);
    end

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] onehot(mdl_t m);
        return (m.offer || m.own) ? (64'd1 << m.k) : 64'd0;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("w4 gnt_v", 64'(gv4), 64'(m4.offer));
            chk("w4 busy",  64'(bz4), 64'(m4.own));
            chk("w4 gnt",   64'(g4),  onehot(m4));
            chk("w4 ptr",   64'(u4.ptr), 64'(m4.ptr));
            if (m4.offer || m4.own) chk("w4 gnt_enc", 64'(e4), 64'(m4.k));
            chk("w5 gnt_v", 64'(gv5), 64'(m5.offer));
            chk("w5 busy",  64'(bz5), 64'(m5.own));
            chk("w5 gnt",   64'(g5),  onehot(m5));
            chk("w5 ptr",   64'(u5.ptr), 64'(m5.ptr));
            if (m5.offer || m5.own) chk("w5 gnt_enc", 64'(e5), 64'(m5.k));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int waits;

        cyc();
        chk_en = 1'b1;
        cyc();
        chk("rst gnt_v", 64'(gv4), 64'd0);
        chk("rst gnt",   64'(g4),  64'd0);
        chk("rst gnt_enc", 64'(e4), 64'd0);
        chk("rst busy",  64'(bz4), 64'd0);
        chk("rst ptr",   64'(u4.ptr), 64'd0);

        // Basic grant
        rst = 1'b0; r4 = 4'b0100;
        cyc();
        chk("basic gnt_v", 64'(gv4), 64'd1);
        chk("basic gnt",   64'(g4),  64'b0100);
        chk("basic enc",   64'(e4),  64'd2);
        a4 = 1'b1;
        cyc();
        a4 = 1'b0;
        chk("ack busy", 64'(bz4), 64'd1);
        chk("ack gnt_v", 64'(gv4), 64'd0);
        chk("ack ptr",  64'(u4.ptr), 64'd3);
        chk("ack gnt",  64'(g4), 64'b0100);

        // Release to idle, then wrap search from ptr=3
        r4 = 4'b0000; l4 = 1'b1;
        cyc();
        l4 = 1'b0;
        chk("rel idle gnt", 64'(g4), 64'd0);
        r4 = 4'b0011;
        cyc();
        chk("wrap enc", 64'(e4), 64'd0);
        a4 = 1'b1;
        cyc();
        a4 = 1'b0; l4 = 1'b1;
        cyc();
        l4 = 1'b0;
        chk("rot enc", 64'(e4), 64'd1);
        chk("rot gnt_v", 64'(gv4), 64'd1);
        chk("rot busy", 64'(bz4), 64'd0);
        // Higher-priority arrivals and stray rel must not disturb the offer
        r4 = 4'b1111; l4 = 1'b1;
        cyc();
        l4 = 1'b0;
        chk("stable enc", 64'(e4), 64'd1);
        a4 = 1'b1;
        cyc();
        a4 = 1'b0;
        chk("rot ptr", 64'(u4.ptr), 64'd2);

        // Withdraw without ack
        r4 = 4'b0010; l4 = 1'b1;
        cyc();
        l4 = 1'b0;
        chk("wd offer enc", 64'(e4), 64'd1);
        r4 = 4'b0000;
        cyc();
        chk("wd gnt_v", 64'(gv4), 64'd0);
        chk("wd gnt", 64'(g4), 64'd0);
        chk("wd ptr", 64'(u4.ptr), 64'd2);
        // Ignored ack/rel in IDLE with no requests
        a4 = 1'b1; l4 = 1'b1;
        cyc();
        a4 = 1'b0; l4 = 1'b0;
        chk("idle ign gnt_v", 64'(gv4), 64'd0);
        // Withdraw coinciding with ack: ack wins
        r4 = 4'b0010;
        cyc();
        r4 = 4'b0000; a4 = 1'b1;
        cyc();
        a4 = 1'b0;
        chk("wd+ack busy", 64'(bz4), 64'd1);
        chk("wd+ack gnt", 64'(g4), 64'b0010);

        // Handover from owner k=2
        r4 = 4'b0100; l4 = 1'b1;
        cyc();
        l4 = 1'b0; a4 = 1'b1;
        cyc();
        a4 = 1'b0;
        r4 = 4'b1001; l4 = 1'b1;
        cyc();
        l4 = 1'b0;
        chk("ho gnt_v", 64'(gv4), 64'd1);
        chk("ho gnt", 64'(g4), 64'b1000);
        chk("ho busy", 64'(bz4), 64'd0);
        a4 = 1'b1;
        cyc();
        a4 = 1'b0;

        // Reset while owned, with rel and req present
        rst = 1'b1; l4 = 1'b1; r4 = 4'b1111;
        cyc();
        rst = 1'b0; l4 = 1'b0; r4 = 4'b1010;
        chk("mid rst gnt", 64'(g4), 64'd0);
        chk("mid rst busy", 64'(bz4), 64'd0);
        chk("mid rst ptr", 64'(u4.ptr), 64'd0);
        cyc();
        chk("post rst enc", 64'(e4), 64'd1);
        // Reset during an offer
        rst = 1'b1;
        cyc();
        rst = 1'b0; r4 = 4'b0000;
        chk("offer rst gnt_v", 64'(gv4), 64'd0);
        cyc();

        // Fairness on W=5
        r5 = 5'b11111;
        for (int n = 0; n < 6; n++) begin
            waits = 0;
            while (!gv5 && waits < 4) begin
                cyc();
                waits++;
            end
            chk("fair enc", 64'(e5), 64'(n % 5));
            a5 = 1'b1;
            cyc();
            a5 = 1'b0; l5 = 1'b1;
            cyc();
            l5 = 1'b0;
        end
        r5 = 5'b00000;
        a5 = 1'b1;
        cyc();
        a5 = 1'b0; l5 = 1'b1;
        cyc();
        l5 = 1'b0;
        cyc();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rr_sched.md
# rr_sched

Round-robin scheduler that shares a single downstream resource among `W` requesters. Each cycle it searches the request vector for the first set bit at or after a rotating priority pointer, wrapping past bit `W-1` to bit 0. It issues that requester a registered one-hot grant with its encoded index, then holds the resource until the owner releases it. It sits between the requesting agents and the shared resource and is the sequencing controller for the rotating find-first-set selection datapath.

## Interface
- `W`, 8, number of requesters; legal range 2..64, any value (power of two not required)
- `ENC_W`, `$clog2(W)`, localparam; width of the encoded index
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `req`  in  W  request vector; bit i set means requester i wants the resource
- `gnt_ack`  in  1  resource accepts the offered grant
- `rel`  in  1  current owner releases the resource
- `gnt_v`  out  1  grant offered (`gnt` and `gnt_enc` are valid)
- `gnt`  out  W  one-hot grant; all zero when no grant is offered or held
- `gnt_enc`  out  ENC_W  binary index of the granted or owning requester
- `busy`  out  1  resource is owned (an accepted grant is outstanding)

## Operation
- State: `ptr` (ENC_W bits, range 0..W-1) and FSM state ∈ {IDLE, OFFER, OWNED}. All outputs are registered.
- Selection `sel(v, p)`: the lowest index i ≥ p with `v[i]=1`; if there is none, the lowest index i < p with `v[i]=1`; if `v=0`, no match.
- IDLE:
  - If `|req`, latch `k = sel(req, ptr)`, set `gnt = 1<<k`, `gnt_enc = k`, `gnt_v = 1`, and go to OFFER.
  - Otherwise stay in IDLE with `gnt = 0`.
- OFFER: `gnt` and `gnt_enc` stay stable. The selection is not re-evaluated, even if higher-priority requests arrive.
  - `gnt_ack=1`: go to OWNED, `gnt_v <= 0`, `busy <= 1`, `ptr <= (k == W-1) ? 0 : k+1`. `gnt` and `gnt_enc` keep k.
  - `gnt_ack=0` and `req[k]=0`: withdraw. Go to IDLE, `gnt_v <= 0`, `gnt <= 0`, `ptr` unchanged.
  - `gnt_ack=1` and `req[k]=0` in the same cycle: ack wins and the block goes to OWNED.
- OWNED: `busy=1` and `gnt` stays at the one-hot of k. `req` changes are ignored.
  - `rel=1` with `|req` (using the updated `ptr`): go directly to OFFER with the new `k' = sel(req, ptr)` and `busy <= 0`. Back-to-back handover has no IDLE bubble.
  - `rel=1` with `req=0`: go to IDLE, `busy <= 0`, `gnt <= 0`.
- Ignored inputs: `rel` in IDLE/OFFER, and `gnt_ack` in IDLE/OWNED.
- Fairness: because `ptr` advances past each accepted owner, any continuously asserted request is granted within W accepted grants.
- Pointer arithmetic is modulo W with an explicit wrap compare, never a bit-truncation wrap, so non-power-of-two W is correct and `ptr` never exceeds W-1.

## Timing
- Reset (rst=1 at an edge): state=IDLE, `ptr=0`, `gnt_v=0`, `gnt=0`, `gnt_enc=0`, `busy=0`. Reset overrides every other input in the same cycle, and reset mid-OFFER or mid-OWNED drops the grant with no release required.
- Request to offer: `req` sampled in IDLE at edge t gives `gnt_v=1` after edge t (visible in cycle t+1).
- Offer to owned: `gnt_ack` sampled at edge t gives `busy=1`, `gnt_v=0` in cycle t+1.
- Release to next offer: `rel` sampled at edge t gives the new `gnt_v=1` in cycle t+1 (one-cycle handover).
- `gnt_v` and `busy` are never both 1. `gnt` is one-hot or zero in every cycle.
- No combinational path from any input to any output.

## Test plan
- Reset and basic grant (W=4): assert rst, then release, then `req=4'b0100` → one cycle later `gnt_v=1`, `gnt=4'b0100`, `gnt_enc=2`. Then `gnt_ack` → `busy=1`, `ptr=3`.
- Rotation and wrap (W=4): with `ptr=3`, `req=4'b0011` → grant to index 0. Ack, then `rel` → next grant to index 1, and `ptr` becomes 2.
- Fairness (W=5, non-power-of-two): `req=5'b11111` held, ack every offer, rel one cycle after each ack → grant sequence is 0,1,2,3,4,0. `ptr` stays ≤ 4 in every cycle.
- Withdraw: in OFFER for index 1, drop `req[1]` with `gnt_ack=0` → IDLE next cycle, `gnt=0`, `ptr` unchanged. Drop `req[1]` with `gnt_ack=1` in the same cycle → OWNED.
- Handover: in OWNED (k=2, W=4), `req=4'b1001` and `rel=1` → `gnt_v=1`, `gnt=4'b1000`, `busy=0` in the next cycle.
- Mid-operation reset: in OWNED, pulse `rst` alongside `rel` and `req` → all outputs 0, state IDLE, `ptr=0`. The first grant after reset comes from the search starting at index 0.
